// File: rtl/aes128_package.sv
// Shared tower-field types and GF(2^2) normal-basis helpers for the S-box datapath.
package aes128_package;

  typedef logic [1:0] bv2_t;
  typedef logic [3:0] bv4_t;

  localparam bv4_t BV4_ONE  = 4'hF;
  localparam bv4_t BV4_ZERO = 4'h0;

  // GF(2^2) multiply in normal basis {W^2, W}; 2'b11 is the field one.
  function automatic bv2_t bv2_mul(input bv2_t x, input bv2_t y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic bv2_t bv2_scl_n(input bv2_t x);
    return {x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/bv4_mul.sv
// GF(2^4) multiplier over GF(2^2) in normal basis; 4'hF is one, 4'h0 is zero.
module bv4_mul
  import aes128_package::*;
(
  input  bv4_t a,
  input  bv4_t b,
  output bv4_t p
);

  bv2_t e_s;

  assign e_s = bv2_scl_n(bv2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
  assign p   = {bv2_mul(a[3:2], b[3:2]) ^ e_s, bv2_mul(a[1:0], b[1:0]) ^ e_s};

endmodule

// File: rtl/bv4_mac.sv
// Lane-parallel GF(2^4) multiply-accumulate: product register, XOR accumulator and a
// held result register, with valid/ready handshakes upstream and downstream.
module bv4_mac
  import aes128_package::*;
#(
  parameter int NUM_LANES = 4,
  parameter int BEAT_W    = 4
) (
  input  logic                       in_clock,
  input  logic                       in_reset_n,
  input  logic                       in_valid,
  output logic                       out_up_ready,
  input  logic                       in_last,
  input  bv4_t [NUM_LANES-1:0]       in_a,
  input  bv4_t [NUM_LANES-1:0]       in_b,
  output logic                       out_valid,
  input  logic                       in_down_ready,
  output bv4_t [NUM_LANES-1:0]       out_c,
  output logic [BEAT_W-1:0]          out_beats
);

  bv4_t [NUM_LANES-1:0] prod_s;
  bv4_t [NUM_LANES-1:0] prod_r;
  bv4_t [NUM_LANES-1:0] acc_r;
  bv4_t [NUM_LANES-1:0] out_c_r;
  logic [BEAT_W-1:0]    count_r;
  logic [BEAT_W-1:0]    out_beats_r;
  logic                 s1_valid_r;
  logic                 s1_last_r;
  logic                 out_valid_r;
  logic                 accept_s;
  logic                 s1_move_s;
  logic                 last_move_s;
  logic                 up_ready_s;

  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
    if (v == {BEAT_W{1'b1}}) begin
      return v;
    end else begin
      return v + BEAT_W'(1);
    end
  endfunction

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bv4_mul u_mul (
      .a (in_a[i]),
      .b (in_b[i]),
      .p (prod_s[i])
    );
  end

  // Flow control: a last beat may only leave stage 1 when the result register is free or draining.
  always_comb begin
    s1_move_s   = s1_valid_r && (!s1_last_r || !out_valid_r || in_down_ready);
    last_move_s = s1_move_s && s1_last_r;
    up_ready_s  = !s1_valid_r || s1_move_s;
    accept_s    = in_valid && up_ready_s;
  end

  // Stage 1: registered per-lane products and the burst-closing flag.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      prod_r     <= {NUM_LANES{BV4_ZERO}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= in_last;
      prod_r     <= prod_s;
    end else if (s1_move_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: fold non-last products into the accumulator; a last move restarts the burst.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      acc_r   <= {NUM_LANES{BV4_ZERO}};
      count_r <= {BEAT_W{1'b0}};
    end else if (last_move_s) begin
      acc_r   <= {NUM_LANES{BV4_ZERO}};
      count_r <= {BEAT_W{1'b0}};
    end else if (s1_move_s) begin
      acc_r   <= acc_r ^ prod_r;
      count_r <= sat_inc(count_r);
    end
  end

  // Result register: a reload in the handshake cycle keeps out_valid high.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      out_valid_r <= 1'b0;
      out_c_r     <= {NUM_LANES{BV4_ZERO}};
      out_beats_r <= {BEAT_W{1'b0}};
    end else if (last_move_s) begin
      out_valid_r <= 1'b1;
      out_c_r     <= acc_r ^ prod_r;
      out_beats_r <= sat_inc(count_r);
    end else if (out_valid_r && in_down_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_up_ready = up_ready_s;
  assign out_valid    = out_valid_r;
  assign out_c        = out_c_r;
  assign out_beats    = out_beats_r;

endmodule

// File: tb/tb_bv4_mac.sv
// Directed bench for bv4_mac: two instances share stimulus, the second with a 2-bit beat counter.
module tb_bv4_mac;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        down_ready;
  logic        up_ready;
  logic        out_valid;
  logic [15:0] out_c;
  logic [3:0]  out_beats;
  logic        up_ready2;
  logic        out_valid2;
  logic [15:0] out_c2;
  logic [1:0]  out_beats2;

  int checks = 0;
  int fails  = 0;

  bv4_mac #(.NUM_LANES(4), .BEAT_W(4)) dut (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .in_valid      (in_valid),
    .out_up_ready  (up_ready),
    .in_last       (in_last),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .in_down_ready (down_ready),
    .out_c         (out_c),
    .out_beats     (out_beats)
  );

  bv4_mac #(.NUM_LANES(4), .BEAT_W(2)) dut2 (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .in_valid      (in_valid),
    .out_up_ready  (up_ready2),
    .in_last       (in_last),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid2),
    .in_down_ready (down_ready),
    .out_c         (out_c2),
    .out_beats     (out_beats2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat at a negedge, wait (bounded) for acceptance, return at the next negedge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic lst);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = av;
    in_b     = bv;
    in_last  = lst;
    #1;
    while (!up_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (up_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_accept: out_up_ready=%b after %0d cycles, want 1", up_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: out_valid=%b, want 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1;
    in_a = 16'hFFFF; in_b = 16'h6666; down_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_c !== 16'h0000 || out_beats !== 4'h0 || up_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: valid=%b c=%h beats=%h ready=%b, want 0 0000 0 1",
               out_valid, out_c, out_beats, up_ready);
    end
    checks++;
    if (out_valid2 !== 1'b0 || out_beats2 !== 2'h0) begin
      fails++;
      $display("FAIL reset_state2: valid=%b beats=%h, want 0 0", out_valid2, out_beats2);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_result: cycle %0d valid=%b, want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_single_identity();
    send(16'hFFFF, 16'h6666, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_latency_early: valid=%b at t+1, want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_c !== 16'h6666 || out_beats !== 4'h1) begin
      fails++;
      $display("FAIL single_identity: valid=%b c=%h beats=%h, want 1 6666 1", out_valid, out_c, out_beats);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_cancellation();
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out("cancel2");
    checks++;
    if (out_c !== 16'h0000 || out_beats !== 4'h2) begin
      fails++;
      $display("FAIL cancel2: c=%h beats=%h, want 0000 2", out_c, out_beats);
    end
    @(negedge clk);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out("cancel3");
    checks++;
    if (out_c !== 16'hFFFF || out_beats !== 4'h3) begin
      fails++;
      $display("FAIL cancel3: c=%h beats=%h, want FFFF 3", out_c, out_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_lanes();
    send(16'hFFAF, 16'hFF09, 1'b1);
    wait_out("lanes");
    checks++;
    if (out_c !== 16'hFF09 || out_beats !== 4'h1) begin
      fails++;
      $display("FAIL lane_independence: c=%h beats=%h, want FF09 1", out_c, out_beats);
    end
    @(negedge clk);
    // 6*6=3, 6*1=6, 9*1=9 per lane, then fold in 1,2,4,8 per lane
    send(16'h6966, 16'h6FF6, 1'b0);
    send(16'hFFFF, 16'h1248, 1'b1);
    wait_out("products");
    checks++;
    if (out_c !== 16'h2B2B || out_beats !== 4'h2) begin
      fails++;
      $display("FAIL products: c=%h beats=%h, want 2B2B 2", out_c, out_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4];
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (k >= 2 && k <= 5) begin
        if (out_valid !== 1'b1 || out_c !== exp[k-2] || out_beats !== 4'h1) begin
          fails++;
          $display("FAIL b2b_result: k=%0d valid=%b c=%h beats=%h, want 1 %h 1",
                   k, out_valid, out_c, out_beats, exp[k-2]);
        end
      end else if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_idle: k=%0d valid=%b, want 0", k, out_valid);
      end
      if (k < 4) begin
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = exp[k]; in_last = 1'b1;
        #1;
        checks++;
        if (up_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready: k=%0d ready=%b, want 1", k, up_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    down_ready = 1'b0;
    send(16'hFFFF, 16'h1111, 1'b1);
    send(16'hFFFF, 16'h2222, 1'b1);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h3333; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_c !== 16'h1111 || up_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: k=%0d valid=%b c=%h ready=%b, want 1 1111 0", k, out_valid, out_c, up_ready);
      end
      @(negedge clk);
    end
    down_ready = 1'b1;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: ready=%b, want 1", up_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_c !== 16'h2222) begin
      fails++;
      $display("FAIL bp_order2: valid=%b c=%h, want 1 2222", out_valid, out_c);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_c !== 16'h3333) begin
      fails++;
      $display("FAIL bp_order3: valid=%b c=%h, want 1 3333", out_valid, out_c);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_dup: valid=%b, want 0", out_valid);
    end
    // Non-last beats keep accumulating while the output is blocked
    down_ready = 1'b0;
    send(16'hFFFF, 16'h4444, 1'b1);
    send(16'hFFFF, 16'h1111, 1'b0);
    send(16'hFFFF, 16'h2222, 1'b0);
    send(16'hFFFF, 16'h8888, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_c !== 16'h4444 || up_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_flow: valid=%b c=%h ready=%b, want 1 4444 0", out_valid, out_c, up_ready);
    end
    down_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_c !== 16'hBBBB || out_beats !== 4'h3) begin
      fails++;
      $display("FAIL bp_reload: valid=%b c=%h beats=%h, want 1 BBBB 3", out_valid, out_c, out_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out("sat5");
    checks++;
    if (out_c !== 16'hFFFF || out_beats !== 4'h5 || out_beats2 !== 2'h3) begin
      fails++;
      $display("FAIL sat5: c=%h beats=%h beats2=%h, want FFFF 5 3", out_c, out_beats, out_beats2);
    end
    @(negedge clk);
    for (int k = 0; k < 16; k++) send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out("sat17");
    checks++;
    if (out_c !== 16'hFFFF || out_beats !== 4'hF || out_beats2 !== 2'h3) begin
      fails++;
      $display("FAIL sat17: c=%h beats=%h beats2=%h, want FFFF F 3", out_c, out_beats, out_beats2);
    end
    @(negedge clk);
  endtask

  task automatic test_midburst_reset();
    down_ready = 1'b0;
    send(16'hFFFF, 16'h5555, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_c !== 16'h0000 || out_beats !== 4'h0 || up_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_state: valid=%b c=%h beats=%h ready=%b, want 0 0000 0 1",
               out_valid, out_c, out_beats, up_ready);
    end
    rst_n = 1'b1;
    down_ready = 1'b1;
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out("midreset");
    checks++;
    if (out_c !== 16'hFFFF || out_beats !== 4'h1 || out_beats2 !== 2'h1) begin
      fails++;
      $display("FAIL midreset_fresh: c=%h beats=%h beats2=%h, want FFFF 1 1", out_c, out_beats, out_beats2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_identity();
    test_cancellation();
    test_lanes();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_midburst_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/bv4_mac.md
# bv4_mac

Pipelined, lane-parallel GF(2^4) multiply-accumulate engine in the tower-field normal basis used by the S-box datapath. Each lane multiplies one bv4 operand pair per accepted beat and XOR-accumulates the products across a burst. When the beat marked last has been folded in, the block emits one sum per lane. It sits between operand-generation logic and GF(2^8) inner-product and mix stages, with valid/ready flow control on both sides.

## Interface
- NUM_LANES, 4, number of independent GF(2^4) lanes (≥1)
- BEAT_W, 4, width of the beat counter reported with each result (≥1)

- in_clock  input  1  clock; all state updates on the rising edge
- in_reset_n  input  1  reset: synchronous, active-low
- in_valid  input  1  upstream beat valid
- out_up_ready  output  1  block accepts the beat this cycle
- in_last  input  1  beat closes the current accumulation
- in_a  input  NUM_LANES×bv4_t  operand A per lane
- in_b  input  NUM_LANES×bv4_t  operand B per lane
- out_valid  output  1  result valid
- in_down_ready  input  1  downstream accepts the result
- out_c  output  NUM_LANES×bv4_t  per-lane XOR-sum of products
- out_beats  output  BEAT_W  beats in this sum, saturating at 2^BEAT_W−1

## Operation
- Accept: a beat is accepted when in_valid && out_up_ready.
- Stage 1 (product register): on accept, store per-lane product in_a[i]·in_b[i], the in_last flag, and s1_valid=1.
  - The product uses GF(2^4) normal-basis multiplication; the value 4'hF is the field one and 4'h0 is zero.
- Stage 2 (accumulator):
  - s1_move = s1_valid && (!s1_last || !out_valid || in_down_ready).
  - Non-last move: acc[i] ^= prod[i]; beat counter increments, saturating.
  - Last move: out_c[i] = acc[i] ^ prod[i]; out_beats = count+1, saturating; out_valid=1. The accumulator and counter clear to 0 in the same cycle.
- Output register:
  - The result holds stable while out_valid && !in_down_ready.
  - out_valid clears on handshake unless a new last move reloads it in the same cycle.
- Upstream ready: out_up_ready = !s1_valid || s1_move. This is a combinational path from in_down_ready; no skid buffer.
- Lanes are independent. Flow control and in_last are shared by all lanes.
- A single-beat burst (in_last=1 on its only beat) yields a sum equal to that beat's product, with out_beats=1.
- Reset, including mid-burst, discards the partial accumulation and any pending result. The first beat after reset starts a new burst.

## Timing
- Reset values:
  - out_valid=0, out_c=0, out_beats=0, out_up_ready=1.
  - s1_valid=0, acc=0, counter=0.
- Latency: the last beat is accepted in cycle t; out_valid=1 in cycle t+2 if the output register is free.
- Throughput: 1 beat/cycle sustained when in_down_ready=1. Back-to-back single-beat bursts give one result per cycle.
- Backpressure: with in_down_ready=0 and a result pending, at most one further last beat is absorbed (it waits in stage 1). out_up_ready then drops until the handshake.
  - Non-last beats keep flowing into the accumulator while only the output is blocked.
- Simultaneous drain and reload: if the output handshake and a last move happen in the same cycle, out_valid stays 1 and the new sum appears the next cycle.

## Structure
- Shared package aes128_package:
  - existing bv2_t and bv4_t;
  - new constant BV4_ONE = 4'hF;
  - new constant BV4_ZERO = 4'h0.
- Sub-module: the existing GF(2^4) multiplier bv4_mul, instantiated once per lane via generate. No new sub-module is required.

## Test plan
- Reset check: hold in_reset_n=0 with in_valid=1 -> outputs are all zero, out_up_ready=1, and no result appears.
- Single-beat identity: one last beat, a=4'hF, b=4'h6, all lanes -> out_c=4'h6 per lane and out_beats=1, in cycle t+2.
- Cancellation: 2-beat burst with both beats a=b=4'hF -> out_c=4'h0 and out_beats=2. Then a 3-beat burst of F·F -> out_c=4'hF and out_beats=3.
- Lane independence: lane 0 uses a=4'hF, b=4'h9; lane 1 uses b=4'h0; the other lanes use a=4'hF, b=4'hF -> out_c lanes are 9, 0, F, F.
- Backpressure: in_down_ready=0, stream single-beat bursts -> after the first result, the second is held in stage 1 and out_up_ready=0. out_c stays stable.
  - Releasing in_down_ready delivers the results in order, with no loss or duplication.
- Saturation and mid-burst reset:
  - BEAT_W=2, 5-beat burst -> out_beats=3.
  - Assert reset after 2 beats of a burst -> the next 1-beat burst F·F gives out_c=4'hF and out_beats=1.
